// File: rtl/rv_mem_arbiter.sv
// N-port memory arbiter: round-robin address arbitration, in-order data routing.
// Define RV_MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest port index wins).
module rv_mem_arbiter #(
    parameter int NUM_PORTS       = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        Req_Address_vld,
    input  logic [NUM_PORTS*ADDR_W-1:0] Req_Address,
    input  logic [NUM_PORTS-1:0]        Req_MemOp,
    input  logic [2*NUM_PORTS-1:0]      Req_MemOpSize,
    output logic [NUM_PORTS-1:0]        Req_Address_rsp,
    input  logic [NUM_PORTS-1:0]        Req_WData_vld,
    input  logic [NUM_PORTS*DATA_W-1:0] Req_WriteData,
    output logic [DATA_W-1:0]           Req_ReadData,
    output logic [NUM_PORTS-1:0]        Req_Data_rsp,
    output logic                        Mem_Address_vld,
    output logic [ADDR_W-1:0]           Mem_Address,
    output logic                        Mem_MemOp,
    output logic [1:0]                  Mem_MemOpSize,
    input  logic                        Mem_Address_rsp,
    output logic                        Mem_WData_vld,
    output logic [DATA_W-1:0]           Mem_WriteData,
    input  logic [DATA_W-1:0]           Mem_ReadData,
    input  logic                        Mem_Data_rsp,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] Outstanding,
    output logic                        ProtoErr
);

    localparam int PW   = $clog2(NUM_PORTS);
    localparam int PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW   = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [NUM_PORTS-1:0] ONE = NUM_PORTS'(1);

    logic          locked;
    logic [PW-1:0] grantQ;
    logic [PW-1:0] prioBase;
    logic [PW-1:0] winner;
    logic [PW-1:0] grant;
    logic          handshake;

    logic [PW-1:0]   fifoPort [MAX_OUTSTANDING];
    logic            fifoOp   [MAX_OUTSTANDING];
    logic [PTRW-1:0] wrPtr;
    logic [PTRW-1:0] rdPtr;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic [PW-1:0]   headPort;
    logic            headOp;

    function automatic logic [PTRW-1:0] nextPtr(input logic [PTRW-1:0] p);
        return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CW'(MAX_OUTSTANDING));
    assign empty = (count == '0);

`ifdef RV_MEM_ARB_FIXED_PRIO_EN
    assign prioBase = '0;
`else
    logic [PW-1:0] rrPtr;
    assign prioBase = rrPtr;
`endif

    // First requesting port at or after prioBase, wrapping.
    always_comb begin
        int  idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        winner = prioBase;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (int'(prioBase) + i) % NUM_PORTS;
            if (!found && Req_Address_vld[idx]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

    assign grant           = locked ? grantQ : winner;
    assign Mem_Address_vld = Req_Address_vld[grant] && !full;
    assign Mem_Address     = Req_Address[int'(grant)*ADDR_W +: ADDR_W];
    assign Mem_MemOp       = Req_MemOp[grant];
    assign Mem_MemOpSize   = Req_MemOpSize[2*int'(grant) +: 2];
    assign handshake       = Mem_Address_vld && Mem_Address_rsp;
    assign Req_Address_rsp = handshake ? (ONE << grant) : '0;

    assign push     = handshake;
    assign pop      = Mem_Data_rsp && !empty;
    assign headPort = fifoPort[rdPtr];
    assign headOp   = fifoOp[rdPtr];

    assign Mem_WData_vld = !empty && headOp && Req_WData_vld[headPort];
    assign Mem_WriteData = Req_WriteData[int'(headPort)*DATA_W +: DATA_W];
    assign Req_Data_rsp  = pop ? (ONE << headPort) : '0;
    assign Req_ReadData  = Mem_ReadData;
    assign Outstanding   = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked <= 1'b0;
            grantQ <= '0;
        end else if (handshake) begin
            locked <= 1'b0;
        end else if (Mem_Address_vld) begin
            locked <= 1'b1;
            grantQ <= grant;
        end else begin
            locked <= 1'b0;
        end
    end

`ifndef RV_MEM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr <= '0;
        end else if (handshake) begin
            rrPtr <= (int'(grant) == NUM_PORTS - 1) ? '0 : grant + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            ProtoErr <= 1'b0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifoPort[i] <= '0;
                fifoOp[i]   <= 1'b0;
            end
        end else begin
            ProtoErr <= Mem_Data_rsp && empty;
            if (push) begin
                fifoPort[wrPtr] <= grant;
                fifoOp[wrPtr]   <= Mem_MemOp;
                wrPtr           <= nextPtr(wrPtr);
            end
            if (pop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
